fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the rv32i pipeline: owns the program counter, drives the synchronous instruction memory, and loads the IF/ID pipeline register whose `if_id_instr` feeds decode and `imm_extend` directly. Handles decode stalls with a one-entry hold buffer, so no fetched word is lost or duplicated. Handles EX-stage redirects (taken branch, jal, jalr) by discarding wrong-path fetches.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value after reset; bits [1:0] must be 0.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `stall` input 1: from the hazard unit; when high, the IF/ID register holds its contents.
- `redirect_valid` input 1: from EX; a taken branch or jump this cycle.
- `redirect_pc` input 32: target PC; bits [1:0] are ignored and treated as 0.
- `imem_en` output 1: instruction-memory read enable.
- `imem_addr` output 32: byte address of the read.
- `imem_rdata` input 32: read data, valid one cycle after the `imem_en` cycle.
- `if_id_valid` output 1: the IF/ID register holds a real instruction.
- `if_id_instr` output 32: instruction word to decode and `imm_extend`.
- `if_id_pc` output 32: PC of `if_id_instr`.
- `if_id_pc_plus4` output 32: `if_id_pc + 4`.

## Operation
- **State**
  - `pc_q`: next address to fetch.
  - `pend_q`, `pend_pc_q`: a read is outstanding and its response arrives this cycle.
  - `hold_valid_q`, `hold_instr_q`, `hold_pc_q`: one-entry buffer for a response that arrives while stalled.
  - The IF/ID register.
- **Issue**
  - `issue = rst_n & !stall & !redirect_valid`.
  - `imem_en = issue` and `imem_addr = pc_q`, both combinational.
  - On issue: `pc_q <= pc_q + 4` (mod 2^32), `pend_q <= 1`, `pend_pc_q <= pc_q`. Otherwise `pend_q <= 0`.
- **Redirect** (highest priority, overrides `stall`)
  - `pc_q <= {redirect_pc[31:2], 2'b00}`.
  - `pend_q <= 0`; any response arriving this cycle is dropped.
  - `hold_valid_q <= 0`.
  - `if_id_valid <= 0` and `if_id_instr <= 32'h0000_0013` (nop).
  - `if_id_pc` is unchanged.
- **Stall, no redirect**
  - The IF/ID register holds.
  - If `pend_q`, capture `imem_rdata`/`pend_pc_q` into the hold buffer and set `hold_valid_q`.
  - `pend_q` and `hold_valid_q` are never both set while stalled, because issue requires `!stall`. A depth of 1 is therefore sufficient.
- **Advance (`!stall`, no redirect)**, in priority order:
  - if `hold_valid_q`: IF/ID loads from the hold buffer and `hold_valid_q <= 0`;
  - else if `pend_q`: IF/ID loads `imem_rdata`/`pend_pc_q` with `if_id_valid <= 1`;
  - else: a bubble, `if_id_valid <= 0` and `if_id_instr <=` nop.
- `if_id_pc_plus4` is registered together with `if_id_pc`.
- **Reset values**
  - `pc_q = RESET_PC`, `pend_q = 0`, `hold_valid_q = 0`.
  - `if_id_valid = 0`, `if_id_instr = 32'h0000_0013`.
  - `if_id_pc = 0`, `if_id_pc_plus4 = 4`.
  - `imem_en = 0` while `rst_n` is low.
  - Asserting reset mid-operation discards all outstanding and held fetches immediately.

## Timing
- **Cold start:** first rising edge with `rst_n` high and `stall` low is cycle 0.
  - Cycle 0: `imem_en = 1` with `imem_addr = RESET_PC`.
  - Cycle 1: `if_id_valid = 1` with `if_id_pc = RESET_PC`.
- **Steady state:** one instruction per cycle with consecutive PCs.
- **Redirect penalty:** redirect in cycle t gives fetch of the target in t+1 and the target valid in IF/ID in t+2.
  - IF/ID shows a bubble in t+1.
  - Two wrong-path slots are killed in total: IF/ID and the pending read.
- **Stall release:** the first cycle after `stall` drops delivers the held word (if any) to IF/ID, and a new issue happens in that same cycle.
  - There is no bubble and no duplicate.
- **Stall and redirect in the same cycle:** the redirect wins; IF/ID is flushed even though stalled.
- **PC wrap:** `32'hFFFF_FFFC + 4` wraps to 0.

## Configuration
- `FETCH_STATS_EN`
  - **Defined:** adds two 32-bit outputs, reset to 0 and wrapping at 2^32:
    - `stat_fetched` increments on every IF/ID load with `if_id_valid <= 1`;
    - `stat_redirects` increments on every `redirect_valid` cycle.
  - **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- **Reset then run, `RESET_PC` = 0, stall low:** `imem_rdata` returns `32'h00500093`, `32'hFF700113`, `32'h05402A23`. IF/ID must show those words at pc 0, 4, 8 on three consecutive cycles, with `if_id_pc_plus4` = 4, 8, 12.
- **Stall for 3 cycles in mid-stream (IF/ID holding pc 4, pending pc 8):**
  - During the stall, IF/ID holds pc 4 and `imem_en` = 0.
  - After release, IF/ID shows pc 8 then pc 12, with no gap or repeat.
- **Redirect to `32'h0000_0100` while IF/ID holds pc 8:**
  - Next cycle `if_id_valid` = 0 with instr `32'h00000013`.
  - The cycle after, IF/ID shows pc `32'h100`.
  - pc 12 never appears in IF/ID.
- **Redirect with `stall` high in the same cycle:** IF/ID is flushed and the hold buffer is cleared. After release, the first valid PC is the redirect target.
- **`redirect_pc` = `32'h0000_0203`:** fetch address is `32'h0000_0200`. PC wrap check: redirect to `32'hFFFF_FFFC` gives `if_id_pc_plus4` = 0, and the next fetch is at 0.
- **`rst_n` low mid-stall with hold buffer full:** outputs return to reset values immediately. Restart fetches from `RESET_PC`. With `FETCH_STATS_EN`, after 5 fetches and 1 redirect the counters read 5 and 1.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage : rv32i instruction fetch; PC, imem read, IF/ID register with  |
// |               one-entry stall hold buffer and EX redirect flush.           |
// | Option macro: FETCH_STATS_EN adds stat_fetched / stat_redirects counters.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4
`ifdef FETCH_STATS_EN
  ,output logic [31:0] stat_fetched,
   output logic [31:0] stat_redirects
`endif
);

   localparam logic [31:0] c_nop = 32'h0000_0013;

   logic        issue;
   logic        load_valid;

   logic [31:0] pc_q, pc_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        hold_valid_q, hold_valid_d;
   logic [31:0] hold_instr_q, hold_instr_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;

   assign issue     = rst_n & ~stall & ~redirect_valid;
   assign imem_en   = issue;
   assign imem_addr = pc_q;

   always_comb begin
      pc_d             = pc_q;
      pend_d           = pend_q;
      pend_pc_d        = pend_pc_q;
      hold_valid_d     = hold_valid_q;
      hold_instr_d     = hold_instr_q;
      hold_pc_d        = hold_pc_q;
      if_id_valid_d    = if_id_valid_q;
      if_id_instr_d    = if_id_instr_q;
      if_id_pc_d       = if_id_pc_q;
      if_id_pc_plus4_d = if_id_pc_plus4_q;
      load_valid       = 1'b0;

      if (redirect_valid) begin
         // Redirect beats stall: kill the pending read, the held word and IF/ID.
         pc_d          = {redirect_pc[31:2], 2'b00};
         pend_d        = 1'b0;
         hold_valid_d  = 1'b0;
         if_id_valid_d = 1'b0;
         if_id_instr_d = c_nop;
      end else begin
         if (issue) begin
            pc_d      = pc_q + 32'd4;
            pend_d    = 1'b1;
            pend_pc_d = pc_q;
         end else begin
            pend_d    = 1'b0;
         end

         if (stall) begin
            // No issue while stalled, so at most one response ever needs parking.
            if (pend_q) begin
               hold_valid_d = 1'b1;
               hold_instr_d = imem_rdata;
               hold_pc_d    = pend_pc_q;
            end
         end else if (hold_valid_q) begin
            hold_valid_d     = 1'b0;
            if_id_valid_d    = 1'b1;
            if_id_instr_d    = hold_instr_q;
            if_id_pc_d       = hold_pc_q;
            if_id_pc_plus4_d = hold_pc_q + 32'd4;
            load_valid       = 1'b1;
         end else if (pend_q) begin
            if_id_valid_d    = 1'b1;
            if_id_instr_d    = imem_rdata;
            if_id_pc_d       = pend_pc_q;
            if_id_pc_plus4_d = pend_pc_q + 32'd4;
            load_valid       = 1'b1;
         end else begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = c_nop;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q             <= RESET_PC;
         pend_q           <= 1'b0;
         pend_pc_q        <= 32'd0;
         hold_valid_q     <= 1'b0;
         hold_instr_q     <= c_nop;
         hold_pc_q        <= 32'd0;
         if_id_valid_q    <= 1'b0;
         if_id_instr_q    <= c_nop;
         if_id_pc_q       <= 32'd0;
         if_id_pc_plus4_q <= 32'd4;
      end else begin
         pc_q             <= pc_d;
         pend_q           <= pend_d;
         pend_pc_q        <= pend_pc_d;
         hold_valid_q     <= hold_valid_d;
         hold_instr_q     <= hold_instr_d;
         hold_pc_q        <= hold_pc_d;
         if_id_valid_q    <= if_id_valid_d;
         if_id_instr_q    <= if_id_instr_d;
         if_id_pc_q       <= if_id_pc_d;
         if_id_pc_plus4_q <= if_id_pc_plus4_d;
      end
   end

   assign if_id_valid    = if_id_valid_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc       = if_id_pc_q;
   assign if_id_pc_plus4 = if_id_pc_plus4_q;

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched_q, stat_fetched_d;
   logic [31:0] stat_redirects_q, stat_redirects_d;

   always_comb begin
      stat_fetched_d   = stat_fetched_q;
      stat_redirects_d = stat_redirects_q;
      if (load_valid)     stat_fetched_d   = stat_fetched_q + 32'd1;
      if (redirect_valid) stat_redirects_d = stat_redirects_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched_q   <= 32'd0;
         stat_redirects_q <= 32'd0;
      end else begin
         stat_fetched_q   <= stat_fetched_d;
         stat_redirects_q <= stat_redirects_d;
      end
   end

   assign stat_fetched   = stat_fetched_q;
   assign stat_redirects = stat_redirects_q;
`else
   logic unused_load_valid;
   assign unused_load_valid = load_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage : directed self-checking bench for fetch_stage.             |
// | Revision       : 1.0 - initial release                                     |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_redirects;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef FETCH_STATS_EN
     ,.stat_fetched   (stat_fetched),
      .stat_redirects (stat_redirects)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'hFF70_0113;
         32'h0000_0008: return 32'h0540_2A23;
         default:       return {a[15:0], 16'hBEEF};
      endcase
   endfunction

   // Synchronous instruction memory: data one cycle after the enable cycle.
   initial imem_rdata = 32'd0;
   always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      check_eq({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
      check_eq({tag, "_pc"},    if_id_pc, pc);
      check_eq({tag, "_instr"}, if_id_instr, instr);
      check_eq({tag, "_pc4"},   if_id_pc_plus4, pc + 32'd4);
   endtask

   task automatic expect_bubble(input string tag);
      check_eq({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
      check_eq({tag, "_instr"}, if_id_instr, 32'h0000_0013);
   endtask

   task automatic expect_reset(input string tag);
      expect_bubble(tag);
      check_eq({tag, "_pc"},  if_id_pc, 32'd0);
      check_eq({tag, "_pc4"}, if_id_pc_plus4, 32'd4);
      check_eq({tag, "_en"},  {31'd0, imem_en}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      tick(); tick();
      expect_reset("rst");

      // Cold start and three consecutive instructions.
      rst_n = 1'b1;
      #1;
      check_eq("cold_en",   {31'd0, imem_en}, 32'd1);
      check_eq("cold_addr", imem_addr, 32'd0);
      tick();
      check_eq("c0_valid", {31'd0, if_id_valid}, 32'd0);
      check_eq("c0_addr",  imem_addr, 32'd4);
      tick(); expect_ifid("run0", 32'd0, 32'h0050_0093);
      tick(); expect_ifid("run4", 32'd4, 32'hFF70_0113);
      tick(); expect_ifid("run8", 32'd8, 32'h0540_2A23);

      // Three-cycle stall with pc 12 pending.
      stall = 1'b1;
      #1;
      check_eq("stall_en", {31'd0, imem_en}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("stall_hold_pc", if_id_pc, 32'd8);
         check_eq("stall_en_lo",   {31'd0, imem_en}, 32'd0);
      end
      stall = 1'b0;
      tick(); expect_ifid("rel12", 32'd12, mem_word(32'd12));
      tick(); expect_ifid("rel16", 32'd16, mem_word(32'd16));

      // Redirect to 0x100 while pc 20 is pending.
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      #1;
      check_eq("redir_en", {31'd0, imem_en}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      expect_bubble("redir_flush");
      check_eq("redir_pc_kept", if_id_pc, 32'd16);
      check_eq("redir_fetch",   imem_addr, 32'h100);
      tick(); expect_bubble("redir_bub");
      tick(); expect_ifid("redir_tgt", 32'h100, mem_word(32'h100));

      // Stall fills the hold buffer, then redirect+stall must flush it.
      stall = 1'b1;
      tick(); check_eq("sr_hold_pc", if_id_pc, 32'h100);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
      tick();
      redirect_valid = 1'b0;
      expect_bubble("sr_flush");
      tick(); expect_bubble("sr_still");
      stall = 1'b0;
      #1;
      check_eq("sr_addr", imem_addr, 32'h200);
      tick(); expect_bubble("sr_nohold");
      tick(); expect_ifid("sr_tgt", 32'h200, mem_word(32'h200));

      // PC wrap.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      check_eq("wrap_next_addr", imem_addr, 32'd0);
      tick(); expect_ifid("wrap", 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
      check_eq("wrap_pc4", if_id_pc_plus4, 32'd0);
      tick(); expect_ifid("wrap0", 32'd0, 32'h0050_0093);

      // Reset mid-stall with pc 4 sitting in the hold buffer.
      stall = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      expect_reset("arst");
      tick(); expect_reset("arst_hold");
      rst_n = 1'b1; stall = 1'b0;
      #1;
      check_eq("rs_addr", imem_addr, 32'd0);
      tick(); check_eq("rs_c0_valid", {31'd0, if_id_valid}, 32'd0);
      tick(); expect_ifid("rs0", 32'd0, 32'h0050_0093);
      tick(); tick(); tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      tick();
      redirect_valid = 1'b0;
`ifdef FETCH_STATS_EN
      check_eq("stat_fetched",   stat_fetched,   32'd5);
      check_eq("stat_redirects", stat_redirects, 32'd1);
`endif
      expect_bubble("final_flush");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
